// File: rtl/pq_pkg.sv
// Shared types and constants for the pqvalue modular ALU and its issue logic.
package pq_pkg;

    localparam int unsigned PQ_W        = 23;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned PQ_CNT_W    = $clog2(16);
    localparam int unsigned Q_KYBER     = 3329;
    localparam int unsigned Q_DILITHIUM = 8380417;

    typedef enum logic [1:0] {
        PQ_OP_ILL = 2'b00,
        PQ_OP_ADD = 2'b01,
        PQ_OP_SUB = 2'b10,
        PQ_OP_MUL = 2'b11
    } pq_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } pq_issue_state_e;

    // Operand payload driven towards the ALU.
    typedef struct packed {
        logic [PQ_W-1:0] a;
        logic [PQ_W-1:0] b;
        logic [1:0]      op;
    } pq_alu_req_t;

    function automatic logic [XLEN-1:0] pq_modulus(input logic kyber);
        return kyber ? XLEN'(Q_KYBER) : XLEN'(Q_DILITHIUM);
    endfunction

endpackage

// File: rtl/pq_wait_cnt.sv
// Loadable down-counter with a registered done flag (count reached zero).
module pq_wait_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
        done_d = (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/pq_issue_ctrl.sv
// Issue controller for the pqvalue modular ALU: accept, wait per-op latency, write back.
// Optional operand range check against the selected modulus: define PQ_RANGE_CHECK_EN.
module pq_issue_ctrl
    import pq_pkg::*;
#(
    parameter int unsigned ADDSUB_LAT = 1,
    parameter int unsigned MUL_LAT    = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic            req_kyber_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic [PQ_W-1:0] alu_a_o,
    output logic [PQ_W-1:0] alu_b_o,
    output logic [1:0]      alu_sel_op_o,
    output logic            alu_sel_red_o,
    input  logic [PQ_W-1:0] alu_result_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_err_o
);

    pq_issue_state_e state_q, state_d;
    pq_alu_req_t     alu_q, alu_d;
    logic            alu_red_q, alu_red_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_err_q, wb_err_d;

    logic                accept_c;
    logic                legal_c;
    logic                cnt_load_c;
    logic                cnt_dec_c;
    logic [PQ_CNT_W-1:0] cnt_val_c;
    logic                cnt_done;

    assign req_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == WB) && wb_ready_i));
    assign accept_c    = req_valid_i && req_ready_o;
    assign cnt_val_c   = (req_op_i == PQ_OP_MUL) ? PQ_CNT_W'(MUL_LAT - 1) : PQ_CNT_W'(ADDSUB_LAT - 1);

    // Illegal encodings (and out-of-range operands when checked) bypass the ALU.
`ifdef PQ_RANGE_CHECK_EN
    assign legal_c = (req_op_i != PQ_OP_ILL)
                  && (req_rs1_i < pq_modulus(req_kyber_i))
                  && (req_rs2_i < pq_modulus(req_kyber_i));
`else
    logic unused_upper_c;
    assign legal_c        = (req_op_i != PQ_OP_ILL);
    assign unused_upper_c = ^{req_rs1_i[XLEN-1:PQ_W], req_rs2_i[XLEN-1:PQ_W]};
`endif

    always_comb begin
        state_d    = state_q;
        alu_d      = alu_q;
        alu_red_d  = alu_red_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_err_d   = wb_err_q;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;

        case (state_q)
            IDLE: begin
            end
            EXEC: begin
                if (cnt_done) begin
                    wb_data_d  = XLEN'(alu_result_i);
                    wb_err_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    alu_d      = '0;
                    state_d    = WB;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only happens from IDLE or a completing WB, so it overrides the above.
        if (accept_c) begin
            wb_rd_d = req_rd_i;
            if (legal_c) begin
                alu_d.a    = req_rs1_i[PQ_W-1:0];
                alu_d.b    = req_rs2_i[PQ_W-1:0];
                alu_d.op   = req_op_i;
                alu_red_d  = req_kyber_i;
                wb_valid_d = 1'b0;
                cnt_load_c = 1'b1;
                state_d    = EXEC;
            end else begin
                wb_data_d  = '0;
                wb_err_d   = 1'b1;
                wb_valid_d = 1'b1;
                state_d    = WB;
            end
        end

        if (flush_i) begin
            state_d    = IDLE;
            wb_valid_d = 1'b0;
            alu_d      = '0;
            cnt_dec_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            alu_q      <= '0;
            alu_red_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_q      <= alu_d;
            alu_red_q  <= alu_red_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_err_q   <= wb_err_d;
        end
    end

    pq_wait_cnt #(
        .W(PQ_CNT_W)
    ) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load_c),
        .load_val_i (cnt_val_c),
        .dec_i      (cnt_dec_c),
        .done_o     (cnt_done)
    );

    assign alu_a_o       = alu_q.a;
    assign alu_b_o       = alu_q.b;
    assign alu_sel_op_o  = alu_q.op;
    assign alu_sel_red_o = alu_red_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_data_o     = wb_data_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_err_o      = wb_err_q;

endmodule

// File: tb/tb_pq_issue_ctrl.sv
// Directed and randomized bench for pq_issue_ctrl with a transaction-level reference model.
module tb_pq_issue_ctrl;

    localparam int unsigned ADDSUB_LAT = 1;
    localparam int unsigned MUL_LAT    = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = '0;
    logic        req_kyber_i = 1'b0;
    logic [31:0] req_rs1_i = '0;
    logic [31:0] req_rs2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        flush_i = 1'b0;
    logic [22:0] alu_a_o;
    logic [22:0] alu_b_o;
    logic [1:0]  alu_sel_op_o;
    logic        alu_sel_red_o;
    logic [22:0] alu_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    pq_issue_ctrl #(
        .ADDSUB_LAT (ADDSUB_LAT),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_kyber_i   (req_kyber_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rd_i      (req_rd_i),
        .flush_i       (flush_i),
        .alu_a_o       (alu_a_o),
        .alu_b_o       (alu_b_o),
        .alu_sel_op_o  (alu_sel_op_o),
        .alu_sel_red_o (alu_sel_red_o),
        .alu_result_i  (alu_result_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_rd_o       (wb_rd_o),
        .wb_err_o      (wb_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Modular arithmetic done with plain integers: serves as ALU stand-in and expected-value source.
    function automatic logic [22:0] ref_mod(input logic [1:0] op, input logic kyber,
                                            input logic [22:0] a, input logic [22:0] b);
        longint unsigned q, x, y;
        q = kyber ? 64'd3329 : 64'd8380417;
        x = 64'(a) % q;
        y = 64'(b) % q;
        case (op)
            2'b01:   return 23'((x + y) % q);
            2'b10:   return 23'((x + q - y) % q);
            2'b11:   return 23'((x * y) % q);
            default: return 23'(0);
        endcase
    endfunction

    function automatic bit exp_legal(input logic [1:0] op, input logic kyber,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
        if (op == 2'b00) return 1'b0;
`ifdef PQ_RANGE_CHECK_EN
        if (rs1 >= (kyber ? 32'd3329 : 32'd8380417)) return 1'b0;
        if (rs2 >= (kyber ? 32'd3329 : 32'd8380417)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    assign alu_result_i = ref_mod(alu_sel_op_o, alu_sel_red_o, alu_a_o, alu_b_o);

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        req_rd_i    = '0;
        flush_i     = 1'b0;
        wb_ready_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        n_checks++;
        if ({alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o, wb_data_o, wb_rd_o, wb_err_o} !== '0)
            $display("FAIL reset_outputs: a=%0d b=%0d op=%0d red=%0b v=%0b d=%0d rd=%0d err=%0b, required all 0",
                     alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o, wb_data_o, wb_rd_o, wb_err_o);
        else n_pass++;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b required 1", req_ready_o);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_kyber_add();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_kyber_i = 1'b1;
        req_rs1_i = 32'd3000; req_rs2_i = 32'd500; req_rd_i = 5'd7;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL add_ready: got %0b required 1", req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o} !== {23'd3000, 23'd500, 2'b01, 1'b1, 1'b0})
            $display("FAIL add_exec: a=%0d b=%0d op=%0d red=%0b v=%0b required 3000 500 1 1 0",
                     alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({wb_valid_o, wb_data_o, wb_err_o, wb_rd_o, alu_sel_op_o} !== {1'b1, 32'd171, 1'b0, 5'd7, 2'b00})
            $display("FAIL add_wb: v=%0b d=%0d err=%0b rd=%0d op=%0d required 1 171 0 7 0",
                     wb_valid_o, wb_data_o, wb_err_o, wb_rd_o, alu_sel_op_o);
        else n_pass++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        n_checks++;
        if (wb_valid_o !== 1'b0) $display("FAIL add_drain: wb_valid=%0b required 0", wb_valid_o);
        else n_pass++;
    endtask

    task automatic test_dil_mul_stall();
        req_valid_i = 1'b1; req_op_i = 2'b11; req_kyber_i = 1'b0;
        req_rs1_i = 32'd8380416; req_rs2_i = 32'd8380416; req_rd_i = 5'd12;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            n_checks++;
            if ({req_ready_o, wb_valid_o, alu_sel_op_o} !== {1'b0, 1'b0, 2'b11})
                $display("FAIL mul_exec%0d: ready=%0b v=%0b op=%0d required 0 0 3",
                         i, req_ready_o, wb_valid_o, alu_sel_op_o);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wb_valid_o, wb_data_o, wb_err_o, wb_rd_o} !== {1'b1, 32'd1, 1'b0, 5'd12})
                $display("FAIL mul_hold%0d: v=%0b d=%0d err=%0b rd=%0d required 1 1 0 12",
                         i, wb_valid_o, wb_data_o, wb_err_o, wb_rd_o);
            else n_pass++;
            tick();
        end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        n_checks++;
        if (wb_valid_o !== 1'b0) $display("FAIL mul_drain: wb_valid=%0b required 0", wb_valid_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        req_valid_i = 1'b1; req_op_i = 2'b10; req_kyber_i = 1'b0;
        req_rs1_i = 32'd5; req_rs2_i = 32'd10; req_rd_i = 5'd3;
        tick();
        req_valid_i = 1'b0;
        tick();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_kyber_i = 1'b1;
        req_rs1_i = 32'd100; req_rs2_i = 32'd200; req_rd_i = 5'd4;
        wb_ready_i = 1'b1;
        #1;
        n_checks++;
        if ({wb_valid_o, wb_data_o, wb_rd_o, req_ready_o} !== {1'b1, 32'd8380412, 5'd3, 1'b1})
            $display("FAIL b2b_first: v=%0b d=%0d rd=%0d ready=%0b required 1 8380412 3 1",
                     wb_valid_o, wb_data_o, wb_rd_o, req_ready_o);
        else n_pass++;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({alu_sel_op_o, alu_a_o, alu_b_o, wb_valid_o} !== {2'b01, 23'd100, 23'd200, 1'b0})
            $display("FAIL b2b_exec: op=%0d a=%0d b=%0d v=%0b required 1 100 200 0",
                     alu_sel_op_o, alu_a_o, alu_b_o, wb_valid_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({wb_valid_o, wb_data_o, wb_rd_o} !== {1'b1, 32'd300, 5'd4})
            $display("FAIL b2b_second: v=%0b d=%0d rd=%0d required 1 300 4", wb_valid_o, wb_data_o, wb_rd_o);
        else n_pass++;
        tick();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_illegal();
        req_valid_i = 1'b1; req_op_i = 2'b00; req_kyber_i = 1'b0;
        req_rs1_i = 32'd77; req_rs2_i = 32'd88; req_rd_i = 5'd9;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({wb_valid_o, wb_err_o, wb_data_o, wb_rd_o, alu_sel_op_o} !== {1'b1, 1'b1, 32'd0, 5'd9, 2'b00})
            $display("FAIL illegal_wb: v=%0b err=%0b d=%0d rd=%0d op=%0d required 1 1 0 9 0",
                     wb_valid_o, wb_err_o, wb_data_o, wb_rd_o, alu_sel_op_o);
        else n_pass++;
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        n_checks++;
        if ({wb_valid_o, alu_sel_op_o} !== 3'b000)
            $display("FAIL illegal_drain: v=%0b op=%0d required 0 0", wb_valid_o, alu_sel_op_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic seen;
        req_valid_i = 1'b1; req_op_i = 2'b11; req_kyber_i = 1'b1;
        req_rs1_i = 32'd11; req_rs2_i = 32'd13; req_rd_i = 5'd21;
        tick();
        req_valid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if ({wb_valid_o, alu_sel_op_o, req_ready_o} !== 4'b0001)
            $display("FAIL flush_idle: v=%0b op=%0d ready=%0b required 0 0 1", wb_valid_o, alu_sel_op_o, req_ready_o);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | wb_valid_o;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL flush_no_wb: wb_valid seen=%0b required 0", seen);
        else n_pass++;
        flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 2'b01;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b0) $display("FAIL flush_ready: got %0b required 0", req_ready_o);
        else n_pass++;
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0;
        n_checks++;
        if ({alu_sel_op_o, wb_valid_o} !== 3'b000)
            $display("FAIL flush_reject: op=%0d v=%0b required 0 0", alu_sel_op_o, wb_valid_o);
        else n_pass++;
        tick();
        n_checks++;
        if (wb_valid_o !== 1'b0) $display("FAIL flush_reject_wb: v=%0b required 0", wb_valid_o);
        else n_pass++;
    endtask

    task automatic test_range();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_kyber_i = 1'b1; req_rd_i = 5'd17;
`ifdef PQ_RANGE_CHECK_EN
        req_rs1_i = 32'd3329; req_rs2_i = 32'd1;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({wb_valid_o, wb_err_o, wb_data_o, alu_sel_op_o} !== {1'b1, 1'b1, 32'd0, 2'b00})
            $display("FAIL range_err: v=%0b err=%0b d=%0d op=%0d required 1 1 0 0",
                     wb_valid_o, wb_err_o, wb_data_o, alu_sel_op_o);
        else n_pass++;
`else
        req_rs1_i = 32'h0080_0005; req_rs2_i = 32'hFF80_0006;
        tick();
        req_valid_i = 1'b0;
        n_checks++;
        if ({alu_a_o, alu_b_o} !== {23'd5, 23'd6})
            $display("FAIL range_trunc: a=%0d b=%0d required 5 6", alu_a_o, alu_b_o);
        else n_pass++;
        tick();
        n_checks++;
        if ({wb_valid_o, wb_err_o, wb_data_o} !== {1'b1, 1'b0, 32'd11})
            $display("FAIL range_result: v=%0b err=%0b d=%0d required 1 0 11", wb_valid_o, wb_err_o, wb_data_o);
        else n_pass++;
`endif
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        req_valid_i = 1'b1; req_op_i = 2'b11; req_kyber_i = 1'b1;
        req_rs1_i = 32'd1000; req_rs2_i = 32'd2000; req_rd_i = 5'd30;
        tick();
        req_valid_i = 1'b0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o, wb_data_o, wb_rd_o, wb_err_o} !== '0)
            $display("FAIL async_reset_outputs: a=%0d op=%0d red=%0b v=%0b rd=%0d required all 0",
                     alu_a_o, alu_sel_op_o, alu_sel_red_o, wb_valid_o, wb_rd_o);
        else n_pass++;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL async_reset_ready: got %0b required 1", req_ready_o);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit          m_busy, m_pend, m_red, exp_ready, acc;
        int          m_rem;
        logic [22:0] m_a, m_b, m_res;
        logic [1:0]  m_op;
        logic [4:0]  m_rd, m_busy_rd;
        logic [31:0] m_data;
        logic        m_err;
        longint unsigned q;
        m_busy = 0; m_pend = 0; m_red = 0; m_rem = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_rd = '0; m_busy_rd = '0; m_data = '0; m_err = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            req_op_i    = 2'($urandom_range(0, 3));
            req_kyber_i = 1'($urandom_range(0, 1));
            q = req_kyber_i ? 64'd3329 : 64'd8380417;
            req_rs1_i   = ($urandom_range(0, 7) == 0) ? $urandom : 32'(64'($urandom) % q);
            req_rs2_i   = ($urandom_range(0, 7) == 0) ? $urandom : 32'(64'($urandom) % q);
            req_rd_i    = 5'($urandom_range(0, 31));
            wb_ready_i  = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 24) == 0);
            #1;
            exp_ready = !flush_i && ((!m_busy && !m_pend) || (m_pend && wb_ready_i));
            n_checks++;
            if ({req_ready_o, wb_valid_o} !== {exp_ready, m_pend})
                $display("FAIL rnd_hs c%0d: ready=%0b v=%0b required %0b %0b",
                         cyc, req_ready_o, wb_valid_o, exp_ready, m_pend);
            else n_pass++;
            if (m_pend) begin
                n_checks++;
                if ({wb_data_o, wb_err_o, wb_rd_o} !== {m_data, m_err, m_rd})
                    $display("FAIL rnd_wb c%0d: d=%0d err=%0b rd=%0d required %0d %0b %0d",
                             cyc, wb_data_o, wb_err_o, wb_rd_o, m_data, m_err, m_rd);
                else n_pass++;
            end
            n_checks++;
            if (m_busy) begin
                if ({alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o} !== {m_a, m_b, m_op, m_red})
                    $display("FAIL rnd_alu c%0d: a=%0d b=%0d op=%0d red=%0b required %0d %0d %0d %0b",
                             cyc, alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, m_a, m_b, m_op, m_red);
                else n_pass++;
            end else begin
                if ({alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o} !== {46'd0, 2'b00, m_red})
                    $display("FAIL rnd_alu_idle c%0d: a=%0d b=%0d op=%0d red=%0b required 0 0 0 %0b",
                             cyc, alu_a_o, alu_b_o, alu_sel_op_o, alu_sel_red_o, m_red);
                else n_pass++;
            end
            acc = req_valid_i && exp_ready;
            if (flush_i) begin
                m_busy = 0;
                m_pend = 0;
            end else begin
                if (m_pend && wb_ready_i) m_pend = 0;
                if (m_busy) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_busy = 0; m_pend = 1; m_data = 32'(m_res); m_err = 0; m_rd = m_busy_rd;
                    end
                end
                if (acc) begin
                    if (!exp_legal(req_op_i, req_kyber_i, req_rs1_i, req_rs2_i)) begin
                        m_pend = 1; m_data = '0; m_err = 1; m_rd = req_rd_i;
                    end else begin
                        m_busy = 1;
                        m_rem  = (req_op_i == 2'b11) ? int'(MUL_LAT) : int'(ADDSUB_LAT);
                        m_a = req_rs1_i[22:0]; m_b = req_rs2_i[22:0]; m_op = req_op_i; m_red = req_kyber_i;
                        m_res = ref_mod(req_op_i, req_kyber_i, req_rs1_i[22:0], req_rs2_i[22:0]);
                        m_busy_rd = req_rd_i;
                    end
                end
            end
            @(posedge clk_i);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_kyber_add();
        test_dil_mul_stall();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_range();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
